// File: rtl/mac_sequencer_pkg.sv
// Shared types and helpers for the matrix-multiply MAC sequencer.
package mac_sequencer_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Index fields are carried at a fixed width; the top slices them down to its own counter widths.
    localparam int IDX_W = 8;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
        logic [IDX_W-1:0] k;
    } idx_tuple_t;

    function automatic int clog2_min1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int pipe_lat(input int mem_lat, input int mult_lat);
        return mem_lat + mult_lat;
    endfunction

endpackage

// File: rtl/mac_align_pipe.sv
// Valid/data shift register that keeps index tuples aligned with operand reads and products.
module mac_align_pipe #(
    parameter int DEPTH = 3,
    parameter int W     = 8,
    parameter int TAP   = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic         vld_i,
    input  logic [W-1:0] dat_i,
    output logic         tap_vld_o,
    output logic         out_vld_o,
    output logic [W-1:0] out_dat_o
);

    logic [DEPTH-1:0]        vld_q;
    logic [DEPTH-1:0][W-1:0] dat_q;

    // Data only moves with a valid bit, so the last stage holds its value between products.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            dat_q <= '0;
        end else if (clr_i) begin
            vld_q <= '0;
        end else if (en_i) begin
            for (int s = DEPTH - 1; s >= 1; s--) begin
                vld_q[s] <= vld_q[s-1];
                if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
            end
            vld_q[0] <= vld_i;
            if (vld_i) dat_q[0] <= dat_i;
        end
    end

    assign tap_vld_o = vld_q[TAP-1];
    assign out_vld_o = vld_q[DEPTH-1];
    assign out_dat_o = dat_q[DEPTH-1];

endmodule

// File: rtl/mac_sequencer.sv
// Walks (i, j, k) for C = A x B, issues operand reads and emits product-aligned indices.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int M        = 4,
    parameter int K        = 4,
    parameter int N        = 4,
    parameter int MEM_LAT  = 1,
    parameter int MULT_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     stall,
    output logic [clog2_min1(M)-1:0] a_row_addr,
    output logic [clog2_min1(K)-1:0] a_col_addr,
    output logic [clog2_min1(K)-1:0] b_row_addr,
    output logic [clog2_min1(N)-1:0] b_col_addr,
    output logic                     rd_en,
    output logic                     mult_en,
    output logic [clog2_min1(M)-1:0] matrix_a_row_addr_counter_reg,
    output logic [clog2_min1(K)-1:0] matrix_a_col_addr_counter_reg,
    output logic [clog2_min1(K)-1:0] matrix_b_row_addr_counter_reg,
    output logic [clog2_min1(N)-1:0] matrix_b_col_addr_counter_reg,
    output logic                     mult_done_reg,
    output logic                     busy,
    output logic                     done
);

    localparam int PIPE_LAT = pipe_lat(MEM_LAT, MULT_LAT);
    localparam int IW       = clog2_min1(M);
    localparam int KW       = clog2_min1(K);
    localparam int JW       = clog2_min1(N);
    localparam int CW       = clog2_min1(PIPE_LAT + 1);

    state_t        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic [JW-1:0] j_q, j_d;
    logic [KW-1:0] k_q, k_d;
    logic [CW-1:0] drn_q, drn_d;

    logic frz, issue, last, kill;

    assign frz   = stall && (state_q == S_RUN || state_q == S_DRAIN);
    assign kill  = abort && (state_q != S_IDLE);
    assign issue = (state_q == S_RUN) && !stall && !abort;
    assign last  = (i_q == IW'(M - 1)) && (j_q == JW'(N - 1)) && (k_q == KW'(K - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            drn_q   <= drn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        drn_d   = drn_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    // k fastest, then j, then i; the final issue wraps everything back to 0
                    if (k_q == KW'(K - 1)) begin
                        k_d = '0;
                        if (j_q == JW'(N - 1)) begin
                            j_d = '0;
                            i_d = (i_q == IW'(M - 1)) ? '0 : i_q + IW'(1);
                        end else begin
                            j_d = j_q + JW'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                    if (last) begin
                        state_d = S_DRAIN;
                        drn_d   = CW'(PIPE_LAT);
                    end
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    if (drn_q == CW'(1)) state_d = S_DONE;
                    else                 drn_d   = drn_q - CW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (kill) begin
            state_d = S_IDLE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            drn_d   = '0;
        end
    end

    idx_tuple_t           t_in, t_out;
    logic                 p_tap, p_vld;
    logic [3*IDX_W-1:0]   p_dat;
    logic                 unused_tout;

    always_comb begin
        t_in       = '0;
        t_in.valid = issue;
        t_in.i     = IDX_W'(i_q);
        t_in.j     = IDX_W'(j_q);
        t_in.k     = IDX_W'(k_q);
    end

    mac_align_pipe #(
        .DEPTH(PIPE_LAT),
        .W    (3 * IDX_W),
        .TAP  (MEM_LAT)
    ) u_pipe (
        .clk      (clk),
        .reset    (reset),
        .en_i     (!frz),
        .clr_i    (kill),
        .vld_i    (t_in.valid),
        .dat_i    ({t_in.i, t_in.j, t_in.k}),
        .tap_vld_o(p_tap),
        .out_vld_o(p_vld),
        .out_dat_o(p_dat)
    );

    assign t_out       = {p_vld, p_dat};
    assign unused_tout = ^t_out;

    assign a_row_addr = i_q;
    assign a_col_addr = k_q;
    assign b_row_addr = k_q;
    assign b_col_addr = j_q;
    assign rd_en      = issue;
    assign mult_en    = p_tap && !frz;
    assign mult_done_reg = p_vld && !frz;

    assign matrix_a_row_addr_counter_reg = t_out.i[IW-1:0];
    assign matrix_a_col_addr_counter_reg = t_out.k[KW-1:0];
    assign matrix_b_row_addr_counter_reg = t_out.k[KW-1:0];
    assign matrix_b_col_addr_counter_reg = t_out.j[JW-1:0];

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: default 4x4x4 instance plus a 1x1x1 instance.
module tb_mac_sequencer;

    logic clk = 1'b0;
    logic reset, start, abort, stall;
    logic [1:0] a_row_addr, a_col_addr, b_row_addr, b_col_addr;
    logic [1:0] m_ai, m_ak, m_bk, m_bj;
    logic rd_en, mult_en, mult_done_reg, busy, done;

    logic start1, abort1, stall1;
    logic [0:0] a1_r, a1_c, b1_r, b1_c, m1_ai, m1_ak, m1_bk, m1_bj;
    logic rd1, me1, md1, bz1, dn1;

    always #5 clk = ~clk;

    mac_sequencer u_dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .stall(stall),
        .a_row_addr(a_row_addr), .a_col_addr(a_col_addr),
        .b_row_addr(b_row_addr), .b_col_addr(b_col_addr),
        .rd_en(rd_en), .mult_en(mult_en),
        .matrix_a_row_addr_counter_reg(m_ai), .matrix_a_col_addr_counter_reg(m_ak),
        .matrix_b_row_addr_counter_reg(m_bk), .matrix_b_col_addr_counter_reg(m_bj),
        .mult_done_reg(mult_done_reg), .busy(busy), .done(done)
    );

    mac_sequencer #(.M(1), .K(1), .N(1)) u_one (
        .clk(clk), .reset(reset), .start(start1), .abort(abort1), .stall(stall1),
        .a_row_addr(a1_r), .a_col_addr(a1_c), .b_row_addr(b1_r), .b_col_addr(b1_c),
        .rd_en(rd1), .mult_en(me1),
        .matrix_a_row_addr_counter_reg(m1_ai), .matrix_a_col_addr_counter_reg(m1_ak),
        .matrix_b_row_addr_counter_reg(m1_bk), .matrix_b_col_addr_counter_reg(m1_bj),
        .mult_done_reg(md1), .busy(bz1), .done(dn1)
    );

    int total = 0;
    int bad   = 0;

    integer ai_a[0:127], aj_a[0:127], ak_a[0:127], bk_a[0:127];
    integer mi_a[0:127], mj_a[0:127], mk_a[0:127], mbk_a[0:127];
    integer rd_a[0:127], md_a[0:127], me_a[0:127], bz_a[0:127];
    int n_rd, f_rd, l_rd, n_md, f_md, l_md, n_dn, f_dn, n_bz, f_bz, l_bz, f_me;

    task automatic check(input string tag, input integer obs, input integer exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start, then drive/record cycles 1..ncyc (cycle c = window after edge c-1).
    task automatic run(input int ncyc, input int stall_at, input int stall_len,
                       input int abort_at, input int xs1, input int xs2);
        n_rd = 0; f_rd = -1; l_rd = -1; n_md = 0; f_md = -1; l_md = -1;
        n_dn = 0; f_dn = -1; n_bz = 0; f_bz = -1; l_bz = -1; f_me = -1;
        for (int c = 0; c < 128; c++) begin
            rd_a[c] = 0; md_a[c] = 0; me_a[c] = 0; bz_a[c] = 0;
        end
        @(negedge clk); start = 1'b1; abort = 1'b0; stall = 1'b0;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            stall = (c >= stall_at) && (c < stall_at + stall_len);
            abort = (c == abort_at);
            start = (c == xs1) || (c == xs2);
            #1;
            ai_a[c] = a_row_addr; aj_a[c] = b_col_addr; ak_a[c] = a_col_addr; bk_a[c] = b_row_addr;
            mi_a[c] = m_ai; mj_a[c] = m_bj; mk_a[c] = m_ak; mbk_a[c] = m_bk;
            rd_a[c] = rd_en; md_a[c] = mult_done_reg; me_a[c] = mult_en; bz_a[c] = busy;
            if (rd_en) begin n_rd++; if (f_rd < 0) f_rd = c; l_rd = c; end
            if (mult_done_reg) begin n_md++; if (f_md < 0) f_md = c; l_md = c; end
            if (done) begin n_dn++; if (f_dn < 0) f_dn = c; end
            if (busy) begin n_bz++; if (f_bz < 0) f_bz = c; l_bz = c; end
            if (mult_en && f_me < 0) f_me = c;
            @(negedge clk);
        end
        start = 1'b0; stall = 1'b0; abort = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; stall1 = 1'b0;

        // reset state
        #12;
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mult_done", mult_done_reg, 0);
        check("rst_mult_en", mult_en, 0);
        check("rst_addr", {a_row_addr, a_col_addr, b_row_addr, b_col_addr}, 0);
        check("rst_aligned", {m_ai, m_ak, m_bk, m_bj}, 0);
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);

        // plain run, address order, product alignment
        run(75, 0, 0, 0, 0, 0);
        check("t1_n_rd", n_rd, 64);
        check("t1_first_rd", f_rd, 1);
        check("t1_last_rd", l_rd, 64);
        check("t1_first_me", f_me, 2);
        check("t1_n_md", n_md, 64);
        check("t1_first_md", f_md, 4);
        check("t1_last_md", l_md, 67);
        check("t1_md4_idx", {mi_a[4], mj_a[4], mk_a[4]}, 0);
        check("t1_n_done", n_dn, 1);
        check("t1_done_cyc", f_dn, 68);
        check("t1_busy_first", f_bz, 1);
        check("t1_busy_last", l_bz, 67);
        check("t1_busy_n", n_bz, 67);
        for (int c = 1; c <= 4; c++) begin
            check("t2_k_seq", ak_a[c], c - 1);
            check("t2_bk_seq", bk_a[c], c - 1);
            check("t2_j0", aj_a[c], 0);
        end
        check("t2_c5_j", aj_a[5], 1);
        check("t2_c5_k", ak_a[5], 0);
        check("t2_c17_i", ai_a[17], 1);
        check("t2_c17_j", aj_a[17], 0);
        check("t2_c64_ijk", ai_a[64] * 16 + aj_a[64] * 4 + ak_a[64], 63);
        check("t2_md7_k", mk_a[7], 3);
        check("t2_md7_bk", mbk_a[7], 3);
        check("t2_md67_ijk", mi_a[67] * 16 + mj_a[67] * 4 + mbk_a[67], 63);
        check("t2_hold_c70", mi_a[70] * 16 + mj_a[70] * 4 + mk_a[70], 63);
        repeat (3) @(negedge clk);

        // 3-cycle stall starting at cycle 10
        run(75, 10, 3, 0, 0, 0);
        check("t3_rd_c10", rd_a[10], 0);
        check("t3_rd_c12", rd_a[12], 0);
        check("t3_md_c11", md_a[11], 0);
        check("t3_me_c11", me_a[11], 0);
        check("t3_hold_k", ak_a[11], 1);
        check("t3_hold_j", aj_a[11], 2);
        check("t3_rd_c13", rd_a[13], 1);
        check("t3_k_c13", ak_a[13], 1);
        check("t3_md_c13", md_a[13], 1);
        check("t3_n_rd", n_rd, 64);
        check("t3_n_md", n_md, 64);
        check("t3_last_md", l_md, 70);
        check("t3_done_cyc", f_dn, 71);
        repeat (3) @(negedge clk);

        // abort in cycle 30, then restart
        run(40, 0, 0, 30, 0, 0);
        check("t4_busy_c30", bz_a[30], 1);
        check("t4_busy_c31", bz_a[31], 0);
        cnt = 0;
        for (int c = 31; c <= 40; c++) cnt += md_a[c] + rd_a[c];
        check("t4_quiet_after", cnt, 0);
        check("t4_no_done", n_dn, 0);
        run(75, 0, 0, 0, 0, 0);
        check("t4_restart_ijk", ai_a[1] * 16 + aj_a[1] * 4 + ak_a[1], 0);
        check("t4_restart_md", f_md, 4);
        check("t4_restart_n_md", n_md, 64);
        check("t4_restart_done", f_dn, 68);
        repeat (3) @(negedge clk);

        // start while busy and in DONE
        run(80, 0, 0, 0, 20, 68);
        check("t5_n_done", n_dn, 1);
        check("t5_done_cyc", f_dn, 68);
        check("t5_busy_last", l_bz, 67);
        check("t5_n_rd", n_rd, 64);
        // start together with abort in IDLE
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            #1; cnt += busy + rd_en + done;
            @(negedge clk);
        end
        check("t5_start_abort", cnt, 0);

        // async reset mid-DRAIN
        run(65, 0, 0, 0, 0, 0);
        #1;
        check("t6_pre_md", mult_done_reg, 1);
        check("t6_pre_mbk", m_bk, 2);
        reset = 1'b1;
        #1;
        check("t6_md", mult_done_reg, 0);
        check("t6_busy", busy, 0);
        check("t6_me", mult_en, 0);
        check("t6_aligned", {m_ai, m_ak, m_bk, m_bj}, 0);
        check("t6_done", done, 0);
        @(negedge clk); reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            #1; cnt += mult_done_reg + busy + done + mult_en;
            @(negedge clk);
        end
        check("t6_no_stale", cnt, 0);

        // 1x1x1 instance
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        n_rd = 0; f_rd = -1; f_md = -1; f_dn = -1; n_dn = 0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (rd1) begin n_rd++; if (f_rd < 0) f_rd = c; end
            if (md1 && f_md < 0) f_md = c;
            if (dn1) begin n_dn++; if (f_dn < 0) f_dn = c; end
            @(negedge clk);
        end
        check("t7_n_rd", n_rd, 1);
        check("t7_rd_cyc", f_rd, 1);
        check("t7_md_cyc", f_md, 4);
        check("t7_done_cyc", f_dn, 5);
        check("t7_n_done", n_dn, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
